jt51_modsrc: RTL and testbench
==============================

Name: jt51_modsrc

Overview:
Operator-output history and modulation-operand generator for the FM operator pipeline. Captures every operator output in the 32-slot sequence (M1, C1, M2, C2 × 8 channels) and keeps per-channel M1 feedback history. Consumes the per-slot source-select strobes (use_prev1, use_prevprev1, use_prev2, use_internal_x, use_internal_y) and the slot-type strobes. Produces the registered phase-modulation operand fed to the phase-generator/operator stage.

Parameters:
W, 14, operator output / modulation width (two's complement)
DLY, 8, slots between consecutive operators of the same channel

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cen  input  1  clock enable; all state advances only when cen=1
zero  input  1  marks slot 0 (first M1 slot, ch0); resynchronises slot counter
op_out  input  W  signed operator output of the slot leaving the operator stage this cycle
m1_enters  input  1  current slot is an M1 operator
m2_enters  input  1  current slot is an M2 operator
c1_enters  input  1  current slot is a C1 operator
c2_enters  input  1  current slot is a C2 operator
use_prev1  input  1  select X = tap D8
use_prevprev1  input  1  select Y = tap D16 (ignored in M1 slots)
use_prev2  input  1  select Y = tap D24
use_internal_x  input  1  select X = tap D16
use_internal_y  input  1  select Y = tap D24
fb  input  3  M1 feedback level of current channel, 0 = off
mod  output  W  registered signed modulation operand
mod_valid  output  1  high one cen-cycle after a slot whose strobe was active

Behaviour:
- Reset (rst_n=0, async): delay line, fb history, slot counter, mod and mod_valid cleared to 0. Reset mid-frame discards all history; the first valid frame follows the next zero.
- Slot counter: 5-bit. On cen&zero it loads 1, else on cen it increments mod 32. ch = counter[2:0].
- Delay line: 24 W-bit stages, shifted by op_out on every cen. Taps: D8 = stage 7, D16 = stage 15, D24 = stage 23, i.e. outputs from 8/16/24 slots earlier.
- M1 feedback history: fb0[8], fb1[8] (W bits each). On cen with m1_enters: fb1[ch]<=fb0[ch], fb0[ch]<=op_out. op_out in an M1 slot is taken as that channel's M1 result.
- Operand select, non-M1 slot:
  - X = use_prev1 ? D8 : use_internal_x ? D16 : 0.
  - Y = use_prevprev1 ? D16 : use_prev2 ? D24 : use_internal_y ? D24 : 0. Priority is left to right when several selects are active.
  - sum = sign-extended (W+1)-bit X+Y; mod_next = sum>>>1, truncated to W.
- M1 slot: the strobes are ignored.
  - fb=0: mod_next=0.
  - Otherwise s = fb0[ch]+fb1[ch] as W+1 bits; mod_next = s>>>(10-fb), sign-extended to W.
- Registration: on cen, mod<=mod_next. mod_valid <= m1_enters|m2_enters|c1_enters|c2_enters. Latency is 1 cen cycle. With cen=0 all outputs hold.
- More than one *_enters strobe active at once is illegal; M1 handling takes priority.
- Saturation: none. The arithmetic shift guarantees no overflow. Extreme check: max positive 0x1FFF+0x1FFF = 0x3FFE, and >>>1 gives 0x1FFF.

Decomposition:
- Shared package jt51_pkg: W, DLY, slot-count constant 32, feedback shift base 10.
- One sub-module, jt51_sh_w: a generic W-bit × N-stage cen-gated shift register with taps, instanced once with N=24.
- Feedback RAM and select logic stay in the top module.

Test Plan:
- Reset: rst_n=0 asserted mid-frame with non-zero history, then released -> mod=0, mod_valid=0; all taps read 0 until refilled.
- Delay taps: feed op_out=slot index (0..31) repeating, zero at slot 0. At slot 20 with c2_enters, use_prev1=1, others 0 -> next cycle mod=(12+0)>>>1=6.
- Sum with sign: at slot 24, D8=-100 and D24=+40, use_prev1 & use_prev2 -> mod=-30.
- M1 feedback: ch3 M1 outputs 0x0400 then 0x0200, fb=7 -> next ch3 M1 mod = 0x0600>>>3 = 0x00C0. With fb=0 -> mod=0.
- Priority/overflow: use_prevprev1 & use_prev2 both set, D16=0x1FFF, D8=0x1FFF with use_prev1 -> mod=0x1FFF (D16 chosen, no wrap).
- cen gating: hold cen=0 for 5 clocks with changing op_out -> taps, counter and mod unchanged. Resume -> sequence continues exactly.

Source files
------------

// File: rtl/jt51_pkg.sv
// Shared widths, tap positions and arithmetic helpers for the jt51 modulation-source path.
// Combinational helpers only; they carry no state of their own.
package jt51_pkg;

  localparam int W       = 14;
  localparam int DLY     = 8;
  localparam int SLOTS   = 32;
  localparam int FB_BASE = 10;

  localparam int NSTAGE  = 3 * DLY;
  localparam int TAP_D8  = DLY - 1;
  localparam int TAP_D16 = 2 * DLY - 1;
  localparam int TAP_D24 = 3 * DLY - 1;

  typedef logic signed [W-1:0] op_t;
  typedef logic signed [W:0]   sum_t;

  typedef struct packed {
    logic prev1;
    logic prevprev1;
    logic prev2;
    logic internal_x;
    logic internal_y;
  } src_sel_t;

  // Halving the (W+1)-bit sum keeps the result inside W bits, so no saturation is needed.
  function automatic op_t half_sum(input op_t a, input op_t b);
    sum_t s;
    s = sum_t'(a) + sum_t'(b);
    return op_t'(s >>> 1);
  endfunction

  // Feedback level 1..7 maps to a right shift of 9..3; level 0 turns feedback off.
  function automatic op_t fb_scale(input op_t a, input op_t b, input logic [2:0] lvl);
    sum_t       s;
    logic [3:0] sh;
    s  = sum_t'(a) + sum_t'(b);
    sh = 4'(FB_BASE) - {1'b0, lvl};
    if (lvl == 3'd0) begin
      return '0;
    end
    return op_t'(s >>> sh);
  endfunction

endpackage

// File: rtl/jt51_sh_w.sv
// Generic W-bit x N-stage shift register with three fixed taps; advances only on cen.
// Tap k presents the input seen k+1 enabled cycles earlier.
module jt51_sh_w #(
  parameter int W     = 14,
  parameter int N     = 24,
  parameter int TAP_A = 7,
  parameter int TAP_B = 15,
  parameter int TAP_C = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] tap_a_o,
  output logic [W-1:0] tap_b_o,
  output logic [W-1:0] tap_c_o
);

  logic [W-1:0] sr_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sr_q[i] <= '0;
      end
    end else if (cen_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < N; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap_a_o = sr_q[TAP_A];
  assign tap_b_o = sr_q[TAP_B];
  assign tap_c_o = sr_q[TAP_C];

endmodule

// File: rtl/jt51_modsrc.sv
// Operator-output history and phase-modulation operand select for the FM pipeline.
// One cen-cycle latency from slot strobes to mod/mod_valid; cen=0 freezes everything.
module jt51_modsrc
  import jt51_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         zero,
  input  logic [W-1:0] op_out,
  input  logic         m1_enters,
  input  logic         m2_enters,
  input  logic         c1_enters,
  input  logic         c2_enters,
  input  logic         use_prev1,
  input  logic         use_prevprev1,
  input  logic         use_prev2,
  input  logic         use_internal_x,
  input  logic         use_internal_y,
  input  logic [2:0]   fb,
  output logic [W-1:0] mod,
  output logic         mod_valid
);

  logic [4:0] cnt_q, cnt_d;
  logic [2:0] ch;
  op_t        mod_q, mod_d;
  logic       vld_q, vld_d;
  op_t        fb0_q [8];
  op_t        fb1_q [8];

  logic [W-1:0] d8, d16, d24;
  op_t          x_sel, y_sel;
  src_sel_t     sel;

  jt51_sh_w #(
    .W     (W),
    .N     (NSTAGE),
    .TAP_A (TAP_D8),
    .TAP_B (TAP_D16),
    .TAP_C (TAP_D24)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen_i   (cen),
    .din_i   (op_out),
    .tap_a_o (d8),
    .tap_b_o (d16),
    .tap_c_o (d24)
  );

  assign sel = '{prev1:      use_prev1,
                 prevprev1:  use_prevprev1,
                 prev2:      use_prev2,
                 internal_x: use_internal_x,
                 internal_y: use_internal_y};

  // zero marks the slot after which the count restarts at 1, so slot 0 always reads as ch0.
  always_comb begin
    cnt_d = cnt_q + 5'd1;
    if (zero) begin
      cnt_d = 5'd1;
    end
    ch = 3'(cnt_q);
  end

  always_comb begin
    x_sel = '0;
    if (sel.prev1) begin
      x_sel = op_t'(d8);
    end else if (sel.internal_x) begin
      x_sel = op_t'(d16);
    end

    y_sel = '0;
    if (sel.prevprev1) begin
      y_sel = op_t'(d16);
    end else if (sel.prev2 || sel.internal_y) begin
      y_sel = op_t'(d24);
    end
  end

  always_comb begin
    mod_d = half_sum(x_sel, y_sel);
    if (m1_enters) begin
      mod_d = fb_scale(fb0_q[ch], fb1_q[ch], fb);
    end
    vld_d = m1_enters | m2_enters | c1_enters | c2_enters;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mod_q <= '0;
      vld_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fb0_q[i] <= '0;
        fb1_q[i] <= '0;
      end
    end else if (cen) begin
      cnt_q <= cnt_d;
      mod_q <= mod_d;
      vld_q <= vld_d;
      // op_out in an M1 slot is that channel's newest M1 result.
      if (m1_enters) begin
        fb1_q[ch] <= fb0_q[ch];
        fb0_q[ch] <= op_t'(op_out);
      end
    end
  end

  assign mod       = mod_q;
  assign mod_valid = vld_q;

endmodule

// File: tb/tb_jt51_modsrc.sv
// Randomised and directed bench for jt51_modsrc against a history-queue reference model.
module tb_jt51_modsrc;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cen = 1'b0;
  logic         zero = 1'b0;
  logic [W-1:0] op_out = '0;
  logic         m1_enters = 1'b0, m2_enters = 1'b0, c1_enters = 1'b0, c2_enters = 1'b0;
  logic         use_prev1 = 1'b0, use_prevprev1 = 1'b0, use_prev2 = 1'b0;
  logic         use_internal_x = 1'b0, use_internal_y = 1'b0;
  logic [2:0]   fb = 3'd0;
  logic [W-1:0] mod;
  logic         mod_valid;

  jt51_modsrc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cen            (cen),
    .zero           (zero),
    .op_out         (op_out),
    .m1_enters      (m1_enters),
    .m2_enters      (m2_enters),
    .c1_enters      (c1_enters),
    .c2_enters      (c2_enters),
    .use_prev1      (use_prev1),
    .use_prevprev1  (use_prevprev1),
    .use_prev2      (use_prev2),
    .use_internal_x (use_internal_x),
    .use_internal_y (use_internal_y),
    .fb             (fb),
    .mod            (mod),
    .mod_valid      (mod_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: every operator output since reset, newest last; per-channel last two M1 outputs.
  int hist[$];
  int fb_last[8];
  int fb_prev[8];
  int mslot;
  int exp_mod;
  int exp_vld;

  // Per-slot frame description: typ 0=M1 1=C1 2=M2 3=C2 4=none; sel = {prev1,prevprev1,prev2,ix,iy}.
  int         fr_val[32];
  int         fr_typ[32];
  logic [4:0] fr_sel[32];
  int         fr_fb[32];
  int         stall_slot = -1;
  int         abort_slot = -1;
  int         lit_slot = -1;
  int         lit_val = 0;
  string      lit_name = "";

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  function automatic int tap(input int k);
    if (hist.size() >= k) return hist[hist.size() - k];
    return 0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) begin
      fb_last[i] = 0;
      fb_prev[i] = 0;
    end
    mslot   = 0;
    exp_mod = 0;
    exp_vld = 0;
  endtask

  // One clock: predict from current inputs, clock, then compare both outputs.
  task automatic cyc();
    int nmod, nvld, x, y, ch, v;
    nmod = 0;
    nvld = 0;
    if (cen && rst_n) begin
      ch = mslot % 8;
      v  = sx(op_out);
      if (m1_enters) begin
        nmod = (fb == 3'd0) ? 0 : ((fb_last[ch] + fb_prev[ch]) >>> (10 - int'(fb)));
      end else begin
        x = use_prev1 ? tap(8) : (use_internal_x ? tap(16) : 0);
        y = use_prevprev1 ? tap(16) : ((use_prev2 || use_internal_y) ? tap(24) : 0);
        nmod = (x + y) >>> 1;
      end
      nvld = (m1_enters || m2_enters || c1_enters || c2_enters) ? 1 : 0;
      hist.push_back(v);
      if (hist.size() > 24) void'(hist.pop_front());
      if (m1_enters) begin
        fb_prev[ch] = fb_last[ch];
        fb_last[ch] = v;
      end
      mslot = zero ? 1 : (mslot + 1) % 32;
    end
    @(posedge clk);
    #1;
    if (cen && rst_n) begin
      exp_mod = nmod;
      exp_vld = nvld;
    end
    check("mod", sx(mod), exp_mod);
    check("mod_valid", int'(mod_valid), exp_vld);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_mod", sx(mod), 0);
    check("reset_mod_valid", int'(mod_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic frame_default(input bit ramp);
    for (int s = 0; s < 32; s++) begin
      fr_val[s] = ramp ? s : 0;
      fr_typ[s] = s / 8;
      fr_sel[s] = 5'b00000;
      fr_fb[s]  = 0;
    end
  endtask

  task automatic frame_random();
    for (int s = 0; s < 32; s++) begin
      fr_val[s] = rnd_op();
      fr_typ[s] = ($urandom_range(7) == 0) ? 4 : s / 8;
      fr_sel[s] = 5'($urandom_range(31));
      fr_fb[s]  = int'($urandom_range(7));
    end
  endtask

  task automatic drive_stall();
    cen  = 1'b0;
    zero = 1'b0;
    op_out = W'(rnd_op());
    {m1_enters, c1_enters, m2_enters, c2_enters} = 4'($urandom_range(15));
    {use_prev1, use_prevprev1, use_prev2, use_internal_x, use_internal_y} = 5'($urandom_range(31));
    fb = 3'($urandom_range(7));
    cyc();
  endtask

  task automatic play_frame(input bit rnd_stall);
    for (int s = 0; s < 32; s++) begin
      if (s == abort_slot) begin
        do_reset();
        abort_slot = -1;
        stall_slot = -1;
        lit_slot   = -1;
        return;
      end
      if (s == stall_slot) begin
        for (int k = 0; k < 5; k++) drive_stall();
      end else if (rnd_stall && $urandom_range(7) == 0) begin
        drive_stall();
      end
      cen       = 1'b1;
      zero      = (s == 0);
      op_out    = W'(fr_val[s]);
      m1_enters = (fr_typ[s] == 0);
      c1_enters = (fr_typ[s] == 1);
      m2_enters = (fr_typ[s] == 2);
      c2_enters = (fr_typ[s] == 3);
      {use_prev1, use_prevprev1, use_prev2, use_internal_x, use_internal_y} = fr_sel[s];
      fb = 3'(fr_fb[s]);
      cyc();
      if (s == lit_slot) check(lit_name, sx(mod), lit_val);
    end
    stall_slot = -1;
    lit_slot   = -1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_mod", sx(mod), 0);
    check("reset_mod_valid", int'(mod_valid), 0);
    rst_n = 1'b1;

    // Ramp frame: D8 at slot 20 holds 12.
    frame_default(1'b1);
    fr_typ[20] = 3;
    fr_sel[20] = 5'b10000;
    lit_slot = 20; lit_val = 6; lit_name = "tap_d8_ramp";
    play_frame(1'b0);

    // Signed sum: D8=-100 (slot 16), D24=+40 (slot 0).
    frame_default(1'b0);
    fr_val[0]  = 40;
    fr_val[16] = -100;
    fr_sel[24] = 5'b10100;
    lit_slot = 24; lit_val = -30; lit_name = "signed_sum";
    play_frame(1'b0);

    // Extreme positive with prevprev1 beating prev2.
    frame_default(1'b0);
    fr_val[8]  = 8191;
    fr_val[16] = 8191;
    fr_sel[24] = 5'b11100;
    lit_slot = 24; lit_val = 8191; lit_name = "max_no_wrap";
    play_frame(1'b0);

    // Channel 3 M1 feedback history.
    frame_default(1'b0);
    fr_val[3] = 1024;
    play_frame(1'b0);
    frame_default(1'b0);
    fr_val[3] = 512;
    play_frame(1'b0);
    frame_default(1'b0);
    fr_fb[3] = 7;
    lit_slot = 3; lit_val = 192; lit_name = "m1_fb7";
    play_frame(1'b0);
    frame_default(1'b0);
    fr_fb[3] = 0;
    fr_sel[3] = 5'b11111;
    lit_slot = 3; lit_val = 0; lit_name = "m1_fb0";
    play_frame(1'b0);

    // Five-clock cen stall mid-frame.
    frame_default(1'b1);
    for (int s = 8; s < 32; s++) fr_sel[s] = 5'b10001;
    stall_slot = 12;
    play_frame(1'b0);

    for (int f = 0; f < 20; f++) begin
      frame_random();
      play_frame(1'b1);
    end

    // Reset mid-frame with live history; D24 must read 0 afterwards.
    frame_random();
    abort_slot = 17;
    play_frame(1'b0);
    frame_random();
    fr_typ[10] = 1;
    fr_sel[10] = 5'b00100;
    lit_slot = 10; lit_val = 0; lit_name = "tap_cleared_by_reset";
    play_frame(1'b0);

    for (int f = 0; f < 20; f++) begin
      frame_random();
      play_frame(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
